div_iter: RTL and testbench

- Parametrised multi-cycle integer divider for the EX stage, radix-2 restoring, one quotient bit per clock.
- Handles signed and unsigned divide in one unit, with a start/busy/done handshake, a cancel input for pipeline flush, and a divide-by-zero flag.
- result packs {remainder, quotient} so the upper half loads HI and the lower half loads LO.

---
 rtl/div_iter.sv | 129 ++++++++++++
 tb/tb_div_iter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Radix-2 restoring divider, signed/unsigned, one quotient bit per clock.
// Define DIV_SHORTCUT_EN to finish early on a zero or oversized divisor.
module div_iter #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               cancel,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic [2*WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             q_neg;
  logic             r_neg;
  logic             dz;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             b_zero;
  logic             go_short;
  logic [WIDTH:0]   shift;
  logic [WIDTH:0]   diff;
  logic             ge;

  assign a_abs  = (signed_op & dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_abs  = (signed_op & divisor[WIDTH-1])  ? -divisor  : divisor;
  assign b_zero = (b_abs == '0);

`ifdef DIV_SHORTCUT_EN
  assign go_short = b_zero | (b_abs > a_abs);
`else
  assign go_short = 1'b0;
`endif

  // Trial subtract on the shifted partial remainder, one extra bit for sign
  assign shift = {rem, quo[WIDTH-1]};
  assign diff  = shift - {1'b0, dvs};
  assign ge    = ~diff[WIDTH];

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = go_short ? FIX : CALC;
      CALC: begin
        if (cancel)
          state_nx = IDLE;
        else if (cnt == CNT_W'(1))
          state_nx = FIX;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dz       <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      result   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            dvs   <= b_abs;
            q_neg <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg <= signed_op & dividend[WIDTH-1];
            dz    <= b_zero;
            cnt   <= CNT_W'(WIDTH);
            rem   <= go_short ? a_abs : '0;
            quo   <= go_short ? {WIDTH{b_zero}} : a_abs;
          end
        end
        CALC: begin
          if (!cancel) begin
            rem <= ge ? diff[WIDTH-1:0] : shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ge};
            cnt <= cnt - CNT_W'(1);
          end
        end
        FIX: begin
          if (!cancel) begin
            // Divide by zero: rem already equals |dividend|, so the
            // remainder sign fix restores the raw dividend.
            result[2*WIDTH-1:WIDTH] <= r_neg ? -rem : rem;
            result[WIDTH-1:0]       <= dz ? '1 : (q_neg ? -quo : quo);
            div_zero                <= dz;
            done                    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed-vector bench for div_iter: table of operations plus
// hand sequences for cancel, back-to-back, held start and async reset.
module tb_div_iter;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           signed_op = 1'b0;
  logic           cancel = 1'b0;
  logic [W-1:0]   dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic           busy;
  logic           done;
  logic           div_zero;
  logic [2*W-1:0] result;

  int total = 0;
  int passed = 0;

  div_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           sg;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] res;
    logic           dz;
    logic           sc;
  } vec_t;

  vec_t v[11];

  task automatic chk(input string nm, input logic [2*W-1:0] act,
                     input logic [2*W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic start_op(input logic sg, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    signed_op = sg;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat counts edges after the accepting edge until done is seen
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!done && lat < 100) begin
      if (busy) bc++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int bc;
    int lat_exp;
    int ndone;
    logic [2*W-1:0] prev;

    v[0]  = '{1'b0, 32'd100,        32'd7,        {32'h2,        32'hE},        1'b0, 1'b0};
    v[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 1'b0};
    v[2]  = '{1'b0, 32'hFFFFFFF9,   32'd2,        {32'h1,        32'h7FFFFFFC}, 1'b0, 1'b0};
    v[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h0,        32'h80000000}, 1'b0, 1'b0};
    v[4]  = '{1'b0, 32'h00001234,   32'h0,        {32'h1234,     32'hFFFFFFFF}, 1'b1, 1'b1};
    v[5]  = '{1'b0, 32'd5,          32'd9,        {32'h5,        32'h0},        1'b0, 1'b1};
    v[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE, {32'h1,        32'hFFFFFFFD}, 1'b0, 1'b0};
    v[7]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'hE},        1'b0, 1'b0};
    v[8]  = '{1'b1, 32'hFFFFFFFB,   32'h0,        {32'hFFFFFFFB, 32'hFFFFFFFF}, 1'b1, 1'b1};
    v[9]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, {32'h0,        32'h1},        1'b0, 1'b0};
    v[10] = '{1'b1, 32'd3,          32'hFFFFFFF7, {32'h3,        32'h0},        1'b0, 1'b1};

    #1;
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_done",     64'(done),     64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    chk("rst_result",   result,        64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      lat_exp = W + 1;
`ifdef DIV_SHORTCUT_EN
      if (v[i].sc) lat_exp = 1;
`endif
      start_op(v[i].sg, v[i].a, v[i].b);
      wait_done(lat, bc);
      chk($sformatf("v%0d_result", i), result, v[i].res);
      chk($sformatf("v%0d_dz", i), 64'(div_zero), 64'(v[i].dz));
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(lat_exp));
      chk($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'(lat_exp));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_done_width", i), 64'(done), 64'd0);
      chk($sformatf("v%0d_hold", i), result, v[i].res);
    end

    // Cancel in the 10th CALC cycle
    prev = v[10].res;
    start_op(1'b0, 32'd1000, 32'd7);
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    cancel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy",   64'(busy), 64'd0);
    chk("cancel_done",   64'(done), 64'd0);
    chk("cancel_result", result,    prev);
    start_op(1'b0, 32'd9, 32'd3);
    wait_done(lat, bc);
    chk("after_cancel_result", result,   {32'h0, 32'h3});
    chk("after_cancel_lat",    64'(lat), 64'(W + 1));

    // Start in the done cycle is accepted
    start_op(1'b1, 32'hFFFFFFF9, 32'd2);
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done(lat, bc);
    chk("b2b_result", result,   {32'hFFFFFFFF, 32'hFFFFFFFD});
    chk("b2b_lat",    64'(lat), 64'(W + 1));
    @(posedge clk);
    @(negedge clk);

    // Start held high while busy: one done only
    ndone = 0;
    signed_op = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (done) ndone++;
    end
    start = 1'b0;
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
      if (done) ndone++;
    end
    chk("held_start_dones",  64'(ndone), 64'd1);
    chk("held_start_result", result,     {32'h2, 32'hE});
    chk("held_start_idle",   64'(busy),  64'd0);

    // Async reset mid-CALC after a divide-by-zero result
    start_op(1'b0, 32'h55, 32'h0);
    wait_done(lat, bc);
    chk("pre_rst_dz", 64'(div_zero), 64'd1);
    start_op(1'b0, 32'd100, 32'd7);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",     64'(busy),     64'd0);
    chk("arst_done",     64'(done),     64'd0);
    chk("arst_div_zero", 64'(div_zero), 64'd0);
    chk("arst_result",   result,        64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("post_rst_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
